// File: rtl/btn_irq_ctrl_pkg.sv
// ============================================================================
// btn_irq_ctrl_pkg : register map and shared defaults for btn_irq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package btn_irq_ctrl_pkg;

    localparam logic [3:0] ADDR_DATA = 4'h0;
    localparam logic [3:0] ADDR_IER  = 4'h4;
    localparam logic [3:0] ADDR_ISR  = 4'h8;
    localparam logic [3:0] ADDR_EDGE = 4'hC;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 10000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : one channel of synchroniser, debounce and edge pulses.
// Build option BTN_IRQ_CTRL_DEBOUNCE_EN enables the stable-sample counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce
    import btn_irq_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   update;
    logic                   next_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

`ifdef BTN_IRQ_CTRL_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             stable;

    // Update is the same condition that commits the new level, so the edge
    // pulse lines up with the cycle the debounced level changes.
    assign next_level = sample;
    assign update     = (sample != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sample == stable) begin
            cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= sample;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

    assign level = stable;
`else
    logic unused_cfg;
    assign unused_cfg = 1'(DEBOUNCE_CYCLES);

    // Level is the last sync stage; the edge is seen one stage earlier.
    assign next_level = sync_q[SYNC_STAGES-2];
    assign update     = sync_q[SYNC_STAGES-2] != sync_q[SYNC_STAGES-1];
    assign level      = sample;
`endif

    assign rise = update & next_level;
    assign fall = update & ~next_level;

endmodule

`default_nettype wire

// File: rtl/btn_irq_ctrl.sv
// ============================================================================
// btn_irq_ctrl : N_BTN button inputs with debounce, edge select, sticky ISR,
// level irq and a strobe-bus register file. Option: BTN_IRQ_CTRL_DEBOUNCE_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_irq_ctrl
    import btn_irq_ctrl_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       wr_addr,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic [3:0]       rd_addr,
    input  logic             rd_en,
    output logic [31:0]      rd_data,
    input  logic [N_BTN-1:0] btn_in,
    output logic             irq
);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] evt;

    logic [N_BTN-1:0] ier;
    logic [N_BTN-1:0] isr;
    logic [N_BTN-1:0] edge_sel;

    logic [31:0]      strb_mask;
    logic [N_BTN-1:0] wr_mask;
    logic [N_BTN-1:0] wr_bits;
    logic [N_BTN-1:0] isr_clr;
    logic             wr_ier;
    logic             wr_isr;
    logic             wr_edge;
    logic [31:0]      rd_mux;

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_chan
            btn_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .btn_in (btn_in[i]),
                .level  (level[i]),
                .rise   (rise[i]),
                .fall   (fall[i])
            );

            assign evt[i] = edge_sel[i] ? fall[i] : rise[i];
        end
    endgenerate

    assign strb_mask = strb_to_mask(wr_strb);
    assign wr_mask   = strb_mask[N_BTN-1:0];
    assign wr_bits   = wr_data[N_BTN-1:0] & wr_mask;

    assign wr_ier  = wr_en && (wr_addr[3:2] == ADDR_IER[3:2]);
    assign wr_isr  = wr_en && (wr_addr[3:2] == ADDR_ISR[3:2]);
    assign wr_edge = wr_en && (wr_addr[3:2] == ADDR_EDGE[3:2]);
    assign isr_clr = wr_isr ? wr_bits : '0;

    always_comb begin
        rd_mux = '0;
        case (rd_addr[3:2])
            ADDR_DATA[3:2]: rd_mux[N_BTN-1:0] = level;
            ADDR_IER[3:2]:  rd_mux[N_BTN-1:0] = ier;
            ADDR_ISR[3:2]:  rd_mux[N_BTN-1:0] = isr;
            ADDR_EDGE[3:2]: rd_mux[N_BTN-1:0] = edge_sel;
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ier      <= '0;
            isr      <= '0;
            edge_sel <= '0;
            irq      <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_ier) begin
                ier <= (ier & ~wr_mask) | wr_bits;
            end
            if (wr_edge) begin
                edge_sel <= (edge_sel & ~wr_mask) | wr_bits;
            end
            // OR-ing events after the clear lets a same-cycle event win.
            isr <= (isr & ~isr_clr) | evt;
            irq <= |(isr & ier);
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_data};

endmodule

`default_nettype wire

// File: tb/tb_btn_irq_ctrl.sv
// ============================================================================
// tb_btn_irq_ctrl : directed and random stimulus against a cycle-level
// behavioural model of btn_irq_ctrl (N_BTN=12, DEBOUNCE_CYCLES=4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_btn_irq_ctrl;
    import btn_irq_ctrl_pkg::*;

    localparam int N = 12;
    localparam int S = 2;
    localparam int D = 4;
`ifdef BTN_IRQ_CTRL_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    localparam int LAT = DEB_ON ? (S + D) : S;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    wr_addr;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic [3:0]    rd_addr;
    logic          rd_en;
    logic [31:0]   rd_data;
    logic [N-1:0]  btn_in;
    logic          irq;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [N-1:0]  hist [S];   // hist[j] = button vector sampled j+1 edges ago
    int            m_run [N];  // consecutive edges the delayed input disagreed
    logic [N-1:0]  m_level, m_ier, m_isr, m_edge;
    logic          m_irq;
    logic [31:0]   m_rd;

    btn_irq_ctrl #(
        .N_BTN           (N),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .btn_in  (btn_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < S; j++) hist[j] = '0;
        for (int c = 0; c < N; c++) m_run[c] = 0;
        m_level = '0; m_ier = '0; m_isr = '0; m_edge = '0;
        m_irq = 1'b0; m_rd = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] nlevel, ev, clr, wm;
        logic [31:0]  bm;
        nlevel = m_level;
        if (DEB_ON) begin
            // Level follows the input seen S edges ago once it has disagreed D times running.
            for (int c = 0; c < N; c++) begin
                if (hist[S-1][c] != m_level[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == D) begin
                        nlevel[c] = hist[S-1][c];
                        m_run[c]  = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end else begin
            nlevel = hist[S-2];
        end
        ev = (nlevel & ~m_level & ~m_edge) | (~nlevel & m_level & m_edge);
        if (rd_en) begin
            case (int'(rd_addr[3:2]))
                0:       m_rd = 32'(m_level);
                1:       m_rd = 32'(m_ier);
                2:       m_rd = 32'(m_isr);
                default: m_rd = 32'(m_edge);
            endcase
        end
        m_irq = |(m_isr & m_ier);
        bm = '0;
        for (int b = 0; b < 4; b++) if (wr_strb[b]) bm[8*b +: 8] = 8'hFF;
        wm  = bm[N-1:0];
        clr = '0;
        if (wr_en) begin
            case (int'(wr_addr[3:2]))
                1:       m_ier  = (m_ier & ~wm) | (wr_data[N-1:0] & wm);
                2:       clr    = wr_data[N-1:0] & wm;
                3:       m_edge = (m_edge & ~wm) | (wr_data[N-1:0] & wm);
                default: ;
            endcase
        end
        m_isr   = (m_isr & ~clr) | ev;
        m_level = nlevel;
        for (int j = S - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = btn_in;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        chk("irq_cycle", 32'(irq), 32'(m_irq));
        chk("rd_cycle", rd_data, m_rd);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        rd_addr = a; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        v = rd_data;
    endtask

    initial begin
        logic [31:0] v;
        int          idx;
        rst = 1'b0; btn_in = '0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_strb = '0;
        model_reset();
        steps(3);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rd", rd_data, 32'h0);
        rst = 1'b1;

        rd(ADDR_DATA, v); chk("rst_data", v, 32'h0);
        rd(ADDR_IER, v);  chk("rst_ier", v, 32'h0);
        rd(ADDR_ISR, v);  chk("rst_isr", v, 32'h0);
        rd(ADDR_EDGE, v); chk("rst_edge", v, 32'h0);

        // Press btn0 with all interrupts enabled; check exact latency.
        wr(ADDR_IER, 32'hF, 4'hF);
        rd_addr = ADDR_DATA; rd_en = 1'b1; btn_in = 12'h001;
        steps(LAT);
        chk("press_data_early", rd_data, 32'h0);
        chk("press_irq_early", 32'(irq), 32'h0);
        step();
        chk("press_data", rd_data, 32'h1);
        chk("press_irq", 32'(irq), 32'h1);
        rd_en = 1'b0;
        rd(ADDR_ISR, v); chk("press_isr", v, 32'h1);
        wr(ADDR_ISR, 32'h1, 4'hF);
        step();
        chk("w1c_irq_drop", 32'(irq), 32'h0);

        // Three-cycle glitch on btn1.
        btn_in[1] = 1'b1; steps(3);
        btn_in[1] = 1'b0; steps(LAT + 3);
        rd(ADDR_DATA, v); chk("glitch_data", v, 32'h1);
        rd(ADDR_ISR, v);  chk("glitch_isr", v, DEB_ON ? 32'h0 : 32'h2);
        chk("glitch_irq", 32'(irq), DEB_ON ? 32'h0 : 32'h1);
        wr(ADDR_ISR, 32'hFFF, 4'hF);

        // Falling-edge mode on btn1 with its interrupt masked.
        wr(ADDR_EDGE, 32'h2, 4'hF);
        wr(ADDR_IER, 32'h0, 4'hF);
        btn_in[1] = 1'b1; steps(LAT + 2);
        rd(ADDR_ISR, v); chk("fall_press_isr", v, 32'h0);
        btn_in[1] = 1'b0; steps(LAT + 2);
        rd(ADDR_ISR, v); chk("fall_release_isr", v, 32'h2);
        chk("fall_masked_irq", 32'(irq), 32'h0);
        wr(ADDR_IER, 32'h2, 4'hF);
        step();
        chk("fall_enable_irq", 32'(irq), 32'h1);

        // W1C in the very cycle a btn0 event fires: the set wins.
        wr(ADDR_ISR, 32'hFFF, 4'hF);
        wr(ADDR_EDGE, 32'h0, 4'hF);
        wr(ADDR_IER, 32'h1, 4'hF);
        btn_in[0] = 1'b0; steps(LAT + 2);
        btn_in[0] = 1'b1; steps(LAT - 1);
        wr(ADDR_ISR, 32'h1, 4'hF);
        rd(ADDR_ISR, v); chk("set_wins_isr", v, 32'h1);
        wr(ADDR_ISR, 32'h1, 4'hF);
        step();
        chk("set_wins_irq_drop", 32'(irq), 32'h0);

        // Byte strobes, width masking, ignored address bits, DATA writes.
        wr(ADDR_IER, 32'hFFFF_FFFF, 4'b0001);
        rd(ADDR_IER, v); chk("strb_low_ier", v, 32'h0000_00FF);
        wr(ADDR_IER, 32'hFFFF_FFFF, 4'hF);
        rd(ADDR_IER, v); chk("strb_full_ier", v, 32'h0000_0FFF);
        rd(4'h5, v);     chk("addr_lsb_ier", v, 32'h0000_0FFF);
        wr(ADDR_DATA, 32'hFFFF_FFFF, 4'hF);
        rd(ADDR_DATA, v); chk("data_write_ignored", v, 32'h1);

        // Reset in the middle of a btn2 debounce, buttons held throughout.
        btn_in = 12'h005;
        steps(3);
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_irq", 32'(irq), 32'h0);
        chk("async_rst_rd", rd_data, 32'h0);
        steps(2);
        rst = 1'b1;
        rd_addr = ADDR_DATA; rd_en = 1'b1;
        steps(LAT);
        chk("rst_rel_data_early", rd_data, 32'h0);
        step();
        chk("rst_rel_data", rd_data, 32'h5);
        rd_en = 1'b0;
        rd(ADDR_ISR, v);  chk("rst_rel_isr", v, 32'h5);
        rd(ADDR_IER, v);  chk("rst_rel_ier", v, 32'h0);
        rd(ADDR_EDGE, v); chk("rst_rel_edge", v, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idx = $urandom_range(0, N - 1);
                btn_in[idx] = ~btn_in[idx];
            end
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_addr = 4'($urandom());
            wr_data = $urandom();
            wr_strb = 4'($urandom());
            rd_en   = 1'($urandom());
            rd_addr = 4'($urandom());
            if (n == 400) begin
                rst = 1'b0;
                model_reset();
                step();
                rst = 1'b1;
            end
            step();
        end
        wr_en = 1'b0; rd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btn_irq_ctrl.md
Name: btn_irq_ctrl

Overview:
Parametrised successor to the 4-button controller. Handles N_BTN button/switch inputs with per-channel synchroniser, debounce, rising/falling edge select, sticky interrupt status and a single level interrupt. Sits on the MicroBlaze peripheral write/read strobe bus beside the other snake I/O blocks. Uses the same 4-register map, extended with an edge-mode register.

Parameters:
N_BTN, 4, number of input channels, 1..32; register bits [31:N_BTN] read 0 and ignore writes
SYNC_STAGES, 2, synchroniser flops per input, minimum 2
DEBOUNCE_CYCLES, 10000, stable-sample count before the debounced level changes, minimum 1; counter width is $clog2(DEBOUNCE_CYCLES+1)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-low reset
wr_addr  in  4  write byte address: 0x0 DATA, 0x4 IER, 0x8 ISR, 0xC EDGE
wr_en  in  1  write strobe, one cycle per write
wr_data  in  32  write data
wr_strb  in  4  byte enables; wr_strb[k] gates bits [8k+7:8k]
rd_addr  in  4  read byte address
rd_en  in  1  read strobe
rd_data  out  32  registered read data
btn_in  in  N_BTN  raw asynchronous button levels, active-high
irq  out  1  registered level interrupt, active-high

Behaviour:
- Reset (rst=0, async): sync chains, debounce counters, debounced levels, IER, ISR, EDGE, rd_data and irq all cleared to 0.
- Sync: btn_in[i] passes through SYNC_STAGES flops.
- Debounce, per channel: if sync sample != stable level, counter increments; when it reaches DEBOUNCE_CYCLES-1, stable level takes the sample and the counter clears. If sample == stable level, counter clears (a glitch restarts the count). Latency from a btn_in change to the DATA change is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Edge event[i] is a one-cycle pulse when stable level changes: rising if EDGE[i]=0, falling if EDGE[i]=1.
- ISR[i] sets on event[i] regardless of IER. Writing 1 to ISR[i] clears it; writing 0 has no effect. If a set and a clear hit the same cycle, the set wins.
- irq <= |(ISR & IER & mask_N), registered, so it asserts 1 cycle after the ISR/IER change. Setting IER with ISR already pending raises irq.
- Writes: when wr_en=1, IER, EDGE and ISR(W1C) update per byte strobe. Writes to DATA or unmapped offsets are ignored. A write to EDGE takes effect on the next event and does not retro-generate events.
- Reads: each cycle rd_en=1, rd_data <= register selected by rd_addr; the value is valid on the next cycle. Otherwise rd_data holds its value. Unmapped offsets read 0. DATA reads the debounced levels. No read side effects.
- rd_addr/wr_addr bits [1:0] are ignored (word aligned).
- Reset mid-debounce: the count is discarded. A button held through reset release produces a rising event after full latency.
- Simultaneous events on several channels: all corresponding ISR bits set in the same cycle.

Optional Feature:
BTN_IRQ_CTRL_DEBOUNCE_EN:
- Defined: debounce counters are present as described above.
- Undefined: stable level = last sync stage. Latency is SYNC_STAGES cycles, no counters are synthesised, and DEBOUNCE_CYCLES is ignored.
- Register map and irq behaviour are identical in both builds.

Decomposition:
- Package btn_irq_ctrl_pkg holds the register offset constants (ADDR_DATA=4'h0, ADDR_IER=4'h4, ADDR_ISR=4'h8, ADDR_EDGE=4'hC) and the default DEBOUNCE_CYCLES.
- One sub-module, btn_debounce (one channel: sync chain, counter, stable level, rise/fall pulses), generated N_BTN times. The top level holds registers, byte-strobe merge, read mux and irq.

Test Plan:
- N_BTN=4, DEBOUNCE_CYCLES=4, debounce on: write IER=0xF, set btn_in=4'b0001 -> DATA reads 0x1 after 2+4 cycles, ISR=0x1, irq=1 one cycle after ISR sets.
- Glitch: btn_in[1] high for 3 cycles then low -> DATA[1] stays 0, ISR unchanged, irq stays 0.
- Write EDGE=0x2, press then release btn[1] -> ISR[1] sets only on release. With IER[1]=0, irq stays 0; then writing IER=0x2 raises irq.
- W1C with a same-cycle event: write ISR=0x1 in the cycle btn[0] event fires -> ISR[0] remains 1. A later write of 0x1 clears it and irq drops next cycle.
- Byte strobe/width: N_BTN=12, write IER=0xFFFF_FFFF with wr_strb=4'b0001 -> IER reads 0x0000_00FF. Full strobe -> reads 0x0000_0FFF. Read of 0x0 DATA after writing to it is unaffected.
- Assert rst=0 mid-count with btn held, release reset -> all registers read 0, irq=0; DATA[0]=1 and ISR[0]=1 after 6 cycles. Repeat without BTN_IRQ_CTRL_DEBOUNCE_EN -> 2-cycle latency.
